onehot_encoder_stream: RTL and testbench
========================================

# onehot_encoder_stream

- Sequential 8-to-3 encoder: the reverse of the 3:8 binary decoder in the datapath library.
- Accepts an 8-bit request vector with a valid/ready handshake and stores it.
- Emits the 3-bit index of each set bit, one per output handshake, in priority order, clearing each bit as it is consumed.
- Sits between request-line producers (interrupt/select lines) and consumers that need binary indices, e.g. a decoder-driven select bus.

## Interface

Parameters:
- PRIORITY_HIGH, default 0, selects scan order: 0 = lowest index first; 1 = highest index first.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer offers in_bits.
- in_ready  output  1  block can accept a vector; high only in IDLE.
- in_bits  input  8  request vector; bit i set = index i requested.
- out_valid  output  1  out_idx/out_last valid.
- out_ready  input  1  consumer accepts current beat.
- out_idx  output  3  binary index of current highest-priority pending bit.
- out_last  output  1  current beat is the final set bit of the vector.
- busy  output  1  high in EMIT state.

## Operation

- State: 2-state FSM (IDLE, EMIT) plus 8-bit pending register.
- Reset (rst_n low, immediate, asynchronous):
  - state = IDLE, pending = 0.
  - out_valid = 0, out_idx = 0, out_last = 0, busy = 0.
  - in_ready = 1 while reset is asserted and after release.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On an edge with in_valid & in_ready and rst_n high: pending <= in_bits.
  - If in_bits != 0, go to EMIT; otherwise behaviour depends on Configuration.
- EMIT:
  - in_ready = 0, out_valid = 1, busy = 1.
  - out_idx = position of the priority bit in pending: lowest set bit if PRIORITY_HIGH=0, highest set bit if 1.
  - out_last = 1 iff exactly one bit of pending is set.
  - On out_valid & out_ready: clear that bit in pending.
  - After that handshake, go to IDLE if out_last, else stay in EMIT.
- out_idx and out_last depend only on registered state; there is no combinational path from in_bits or out_ready to any output.
- in_ready, out_valid and busy depend only on state.
- While out_valid & !out_ready, out_idx and out_last are held stable.
- in_valid is ignored outside IDLE; no vector is dropped or merged.
- Number of output beats per vector = popcount(in_bits).

## Timing

- Input accepted at edge N → out_valid high in the cycle after edge N.
  - First out_idx is valid at that point: latency 1 cycle.
- With out_ready held high, one index per cycle: k set bits take k cycles in EMIT.
- Final handshake at edge M → in_ready high in the cycle after edge M.
  - Minimum vector-to-vector period = popcount + 1 cycles.
- Reset asserted mid-EMIT:
  - out_valid falls immediately and pending clears.
  - No residual beats after release.
- Release of rst_n is assumed synchronized externally; the first possible accept is the first rising edge with rst_n high.

## Configuration

- Macro: ONEHOT_ENCODER_ZERO_BEAT_EN.
- Defined: an accepted all-zero vector produces exactly one beat.
  - The beat carries out_idx=0, out_last=1.
  - Handled via EMIT with a zero flag; latency and handshake are as for a 1-bit vector.
- Undefined: an accepted all-zero vector is consumed silently.
  - State stays IDLE, no output beat, in_ready stays 1 the next cycle.

## Test plan

- PRIORITY_HIGH=0, in_bits=8'b1000_0001, out_ready=1:
  - Beats idx 0 (last=0), then idx 7 (last=1).
  - in_ready returns 1 the cycle after the second beat.
- in_bits=8'hFF, out_ready toggling 1,0,1,0:
  - idx 0..7 in order, 8 beats, last only on idx 7.
  - out_idx/out_last unchanged during every stalled cycle.
- PRIORITY_HIGH=1, in_bits=8'b0010_0110:
  - Beats idx 5, 2, 1; last on idx 1.
- in_bits=8'h00:
  - Macro defined → one beat idx 0, last=1.
  - Undefined → no beat; in_ready stays 1 and a following vector 8'h04 yields idx 2 one cycle after acceptance.
- in_bits=8'h3E, deassert rst_n after 2 beats:
  - out_valid drops within the same cycle; in_ready=1.
  - After release no beats appear until a new vector is accepted.
- in_valid=1 with in_bits=8'h80 held throughout EMIT of 8'h03:
  - Beats idx 0, 1 only.
  - 8'h80 accepted in the first IDLE cycle, then yields idx 7.

Source files
------------

// File: rtl/onehot_encoder_stream.sv
// onehot_encoder_stream: stores an 8-bit request vector and emits one index per set bit in priority order (ONEHOT_ENCODER_ZERO_BEAT_EN: an all-zero vector yields one idx-0 beat)
module onehot_encoder_stream #(
  parameter int PRIORITY_HIGH = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_bits,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_idx,
  output logic       out_last,
  output logic       busy
);
`ifdef ONEHOT_ENCODER_ZERO_BEAT_EN
  localparam bit zero_beat = 1'b1;
`else
  localparam bit zero_beat = 1'b0;
`endif
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state;
  logic [7:0] pending;
  logic zero;
  assign in_ready  = state == IDLE;
  assign out_valid = state == EMIT;
  assign busy      = state == EMIT;
  assign out_last  = zero | (pending != 8'd0 && (pending & (pending - 8'd1)) == 8'd0);
  // later loop iterations win, so scan toward the priority end
  always_comb begin
    out_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (PRIORITY_HIGH != 0 ? pending[i] : pending[7-i])
        out_idx = PRIORITY_HIGH != 0 ? 3'(i) : 3'(7 - i);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= 8'd0;
      zero    <= 1'b0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        pending <= in_bits;
        zero    <= zero_beat && in_bits == 8'd0;
        state   <= (in_bits != 8'd0 || zero_beat) ? EMIT : IDLE;
      end
    end else if (out_ready) begin
      pending[out_idx] <= 1'b0;
      zero             <= 1'b0;
      state            <= out_last ? IDLE : EMIT;
    end
  end
endmodule

// File: tb/tb_onehot_encoder_stream.sv
// tb_onehot_encoder_stream: lowest-first and highest-first instances driven in lockstep against a list-based reference
module tb_onehot_encoder_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_bits = 8'd0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, out_last, busy;
  logic in_ready_h, out_valid_h, out_last_h, busy_h;
  logic [2:0] out_idx, out_idx_h;
  int vec = 0;
  int err = 0;
  always #5 clk = ~clk;
  onehot_encoder_stream #(.PRIORITY_HIGH(0)) dut_lo (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );
  onehot_encoder_stream #(.PRIORITY_HIGH(1)) dut_hi (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_h), .in_bits(in_bits),
    .out_valid(out_valid_h), .out_ready(out_ready), .out_idx(out_idx_h), .out_last(out_last_h), .busy(busy_h)
  );
  logic [13:0] obs;
  logic [5:0] ctl;
  assign obs = {out_valid, busy, in_ready, out_idx, out_last, out_valid_h, busy_h, in_ready_h, out_idx_h, out_last_h};
  assign ctl = {out_valid, busy, in_ready, out_valid_h, busy_h, in_ready_h};
  localparam logic [13:0] reset_obs = 14'b00_1000_0_00_1000_0;
  localparam logic [5:0] idle_ctl = 6'b001001;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vec++;
    if (obs !== reset_obs) begin err++; $display("FAIL reset_held obs=%b exp=%b", obs, reset_obs); end
    rst_n = 1'b1;
    @(negedge clk);
    vec++;
    if (obs !== reset_obs) begin err++; $display("FAIL reset_released obs=%b exp=%b", obs, reset_obs); end
  endtask

  // at a negedge in IDLE: offer v, check every beat, end at the negedge after the final handshake
  task automatic test_stream(input logic [7:0] v, input int mode);
    int ql[$];
    int qh[$];
    int n, i, cyc;
    logic [13:0] e;
    for (int b = 0; b < 8; b++) if (v[b]) ql.push_back(b);
    for (int b = 7; b >= 0; b--) if (v[b]) qh.push_back(b);
`ifdef ONEHOT_ENCODER_ZERO_BEAT_EN
    if (v == 8'd0) begin ql.push_back(0); qh.push_back(0); end
`endif
    n = ql.size();
    vec++;
    if (ctl !== idle_ctl) begin err++; $display("FAIL pre_accept v=%h ctl=%b exp=%b", v, ctl, idle_ctl); end
    in_valid = 1'b1;
    in_bits = v;
    @(negedge clk);
    in_valid = 1'b0;
    in_bits = 8'($urandom);
    i = 0;
    cyc = 0;
    while (i < n && cyc < 100) begin
      e = {3'b110, 3'(ql[i]), i == n - 1, 3'b110, 3'(qh[i]), i == n - 1};
      vec++;
      if (obs !== e) begin err++; $display("FAIL beat v=%h i=%0d obs=%b exp=%b", v, i, obs, e); end
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : 1'($urandom);
      if (out_ready) i++;
      cyc++;
      @(negedge clk);
    end
    vec++;
    if (i < n) begin err++; $display("FAIL timeout v=%h beats=%0d exp=%0d", v, i, n); end
    vec++;
    if (ctl !== idle_ctl) begin err++; $display("FAIL post_vector v=%h ctl=%b exp=%b", v, ctl, idle_ctl); end
  endtask

  task automatic test_hold();
    vec++;
    if (ctl !== idle_ctl) begin err++; $display("FAIL hold_pre ctl=%b exp=%b", ctl, idle_ctl); end
    in_valid = 1'b1;
    in_bits = 8'h03;
    out_ready = 1'b1;
    @(negedge clk);
    in_bits = 8'h80;
    vec++;
    if (obs !== {3'b110, 3'd0, 1'b0, 3'b110, 3'd1, 1'b0}) begin err++; $display("FAIL hold_beat0 obs=%b", obs); end
    @(negedge clk);
    vec++;
    if (obs !== {3'b110, 3'd1, 1'b1, 3'b110, 3'd0, 1'b1}) begin err++; $display("FAIL hold_beat1 obs=%b", obs); end
    @(negedge clk);
    vec++;
    if (ctl !== idle_ctl) begin err++; $display("FAIL hold_idle ctl=%b exp=%b", ctl, idle_ctl); end
    @(negedge clk);
    in_valid = 1'b0;
    vec++;
    if (obs !== {3'b110, 3'd7, 1'b1, 3'b110, 3'd7, 1'b1}) begin err++; $display("FAIL hold_next obs=%b", obs); end
    @(negedge clk);
    vec++;
    if (ctl !== idle_ctl) begin err++; $display("FAIL hold_done ctl=%b exp=%b", ctl, idle_ctl); end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1;
    in_bits = 8'h3E;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    vec++;
    if (obs !== {3'b110, 3'd1, 1'b0, 3'b110, 3'd5, 1'b0}) begin err++; $display("FAIL mid_beat0 obs=%b", obs); end
    @(negedge clk);
    vec++;
    if (obs !== {3'b110, 3'd2, 1'b0, 3'b110, 3'd4, 1'b0}) begin err++; $display("FAIL mid_beat1 obs=%b", obs); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vec++;
    if (obs !== reset_obs) begin err++; $display("FAIL mid_reset obs=%b exp=%b", obs, reset_obs); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vec++;
      if (ctl !== idle_ctl) begin err++; $display("FAIL mid_residual ctl=%b exp=%b", ctl, idle_ctl); end
    end
  endtask

  task automatic test_random();
    logic [7:0] v;
    for (int k = 0; k < 40; k++) begin
      v = $urandom_range(0, 7) == 0 ? 8'd0 : 8'($urandom);
      test_stream(v, 2);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        vec++;
        if (ctl !== idle_ctl) begin err++; $display("FAIL rand_gap ctl=%b exp=%b", ctl, idle_ctl); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream(8'h81, 0);
    test_stream(8'hFF, 1);
    test_stream(8'h26, 0);
    test_stream(8'h00, 0);
    test_stream(8'h04, 0);
    test_hold();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
